// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin I/D-cache arbiter onto one memory bus, burst-locked grants
// Optional CACHE_ARB_STATS_EN adds read-only grant/conflict counters.
module cache_mem_arbiter #(
  parameter int BLOCK_SIZE = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_byte_en,
  output logic [31:0]       i_rdata,
  output logic              i_busy,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byte_en,
  output logic [31:0]       d_rdata,
  output logic              d_busy,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_ren,
  output logic              m_wen,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_byte_en,
  input  logic [31:0]       m_rdata,
  input  logic              m_busy,
  output logic [1:0]        owner
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt_i,
  output logic [31:0]       grant_cnt_d,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;

  // State encoding doubles as the owner debug code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_served_q, last_served_d;

  logic req_i, req_d;
  logic own_req;
  logic beat_done;
  logic last_beat;

  assign req_i     = i_ren | i_wen;
  assign req_d     = d_ren | d_wen;
  assign own_req   = (state_q == OWN_I) ? req_i : req_d;
  assign beat_done = (state_q != IDLE) && own_req && !m_busy;
  assign last_beat = (beat_cnt_q == CNT_W'(BLOCK_SIZE - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      last_served_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      last_served_q <= last_served_d;
    end
  end

  // last_served: 0 = I-cache, 1 = D-cache; a tie goes to the other one.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = last_served_q ? OWN_I : OWN_D;
        end else if (req_i) begin
          state_d = OWN_I;
        end else if (req_d) begin
          state_d = OWN_D;
        end
      end
      OWN_I, OWN_D: begin
        if ((beat_done && last_beat) || !own_req) begin
          state_d       = IDLE;
          beat_cnt_d    = '0;
          last_served_d = (state_q == OWN_D);
        end else if (beat_done) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    m_addr    = '0;
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    m_wdata   = '0;
    m_byte_en = '0;
    i_rdata   = '0;
    d_rdata   = '0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    case (state_q)
      OWN_I: begin
        m_addr    = i_addr;
        m_ren     = i_ren;
        m_wen     = i_wen;
        m_wdata   = i_wdata;
        m_byte_en = i_byte_en;
        i_rdata   = m_rdata;
        i_busy    = m_busy;
      end
      OWN_D: begin
        m_addr    = d_addr;
        m_ren     = d_ren;
        m_wen     = d_wen;
        m_wdata   = d_wdata;
        m_byte_en = d_byte_en;
        d_rdata   = m_rdata;
        d_busy    = m_busy;
      end
      default: ;
    endcase
  end

  assign owner = state_q;

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] grant_cnt_i_q, grant_cnt_d_q, conflict_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_cnt_i_q  <= '0;
      grant_cnt_d_q  <= '0;
      conflict_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (state_d == OWN_I) grant_cnt_i_q <= grant_cnt_i_q + 32'd1;
      if (state_d == OWN_D) grant_cnt_d_q <= grant_cnt_d_q + 32'd1;
      if (req_i && req_d)   conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_i  = grant_cnt_i_q;
  assign grant_cnt_d  = grant_cnt_d_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester arbiter that shares one memory-side generic bus between the I-cache and D-cache line-fill/writeback ports. It sits between the separate caches' memory-side generic buses and the memory controller, replacing per-cache bus ownership with a single sequenced port. Ownership is locked for a full cache-line burst of `BLOCK_SIZE` word beats, with round-robin selection on contention.

## Interface
Parameters:
- `BLOCK_SIZE`, 2 — word beats per cache-line burst; legal range 1..8.
- `ADDR_W`, 32 — address width.

Ports (`x` = `i` for the I-cache port, `d` for the D-cache port):
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `x_addr` in `ADDR_W` — requester word address.
- `x_ren` / `x_wen` in 1 — requester read/write request; never both high.
- `x_wdata` in 32 — write data.
- `x_byte_en` in 4 — byte enables.
- `x_rdata` out 32 — read data returned to the requester.
- `x_busy` out 1 — low for exactly the cycle in which that requester's beat completes.
- `m_addr` out `ADDR_W`, `m_ren` out 1, `m_wen` out 1, `m_wdata` out 32, `m_byte_en` out 4 — memory-side request.
- `m_rdata` in 32 — memory read data.
- `m_busy` in 1 — memory busy; low means the current beat is done.
- `owner` out 2 — 00 idle, 01 I-cache, 10 D-cache (debug/observability).

## Operation
- States:
  - `IDLE`
  - `OWN_I`
  - `OWN_D`
- Request definitions: `req_i = i_ren|i_wen`; `req_d = d_ren|d_wen`.
- `IDLE` transitions (evaluated at the clock edge):
  - Only one request → move to that requester's `OWN` state.
  - Both → move to the `OWN` state of the requester that is *not* `last_served`.
  - Neither → stay in `IDLE`.
- In `OWN_x`:
  - `m_*` request signals mirror port `x` combinationally.
  - `x_rdata = m_rdata`; `x_busy = m_busy`.
  - The other port sees `busy=1` and `rdata=0`.
- Beat completion: `req_x & ~m_busy` in `OWN_x`. Each completion increments `beat_cnt`, which is `$clog2(BLOCK_SIZE)+1` bits wide.
- Burst end (either condition):
  - Beat completes with `beat_cnt == BLOCK_SIZE-1` → go to `IDLE`, clear `beat_cnt`, set `last_served = x`.
  - `req_x` drops with no beat completing that cycle (early release, e.g. a single-word uncached access) → go to `IDLE`, clear `beat_cnt`, set `last_served = x`.
- In `IDLE`:
  - All `m_*` outputs are 0.
  - Both `x_busy` are 1 and both `x_rdata` are 0.
- Direction is not checked mid-burst. A writeback burst followed by a fill from the same cache is two separate grants.
- Reset (asynchronous, any cycle including mid-beat):
  - State → `IDLE`, `beat_cnt` = 0, `last_served` = I-cache, so the D-cache wins the first tie.
  - Outputs take their `IDLE` values immediately.
  - A beat in flight is abandoned; the memory controller is reset by the same `RST`.

## Timing
- Grant latency:
  - A request first seen in `IDLE` at edge N → `m_ren`/`m_wen` asserted in cycle N+1 (one registered arbitration cycle).
  - If the requester is already owner, there is zero added latency.
- Data path: `m_busy` → `x_busy` and `m_rdata` → `x_rdata` are combinational within the owned cycle; no added beat latency.
- Dead cycle: there is exactly one `IDLE` cycle between any two grants, including back-to-back bursts from the same requester.
- A second requester waiting behind a full burst is granted within `BLOCK_SIZE` beat completions + 1 cycle (starvation bound).
- Simultaneous burst end and new request from the other port: the `IDLE` cycle still occurs; arbitration happens in that cycle.

## Configuration
- `CACHE_ARB_STATS_EN`
- Defined:
  - Adds outputs `grant_cnt_i`, `grant_cnt_d` (32 bits each), incremented on each `IDLE`→`OWN` transition.
  - Adds `conflict_cnt` (32 bits), incremented on each `IDLE` cycle with `req_i & req_d`.
  - All counters wrap at 2^32, reset to 0, and are read-only.
- Undefined: these ports and registers do not exist; arbitration behaviour is identical.

## Test plan
- Reset, then `d_ren=1`, `addr=0x100` alone, `BLOCK_SIZE=2`, memory `busy` for 2 cycles per beat → `m_ren` high from cycle 1; `d_busy` low twice with `rdata` 0xAAAA0000/0xAAAA0001; `owner` returns to 00 after beat 2; `i_busy` stays 1 throughout.
- Both requests in the same cycle after reset → D-cache granted first (`owner`=10); after its 2 beats, one `IDLE` cycle, then `owner`=01.
- Continuous contention for 4 bursts → grants alternate D, I, D, I; no requester waits longer than 2 beats + 1 cycle.
- I-cache single-word read then `i_ren` drops before a second beat → `owner` returns to 00 the cycle after the drop; `beat_cnt` = 0.
- `RST` pulsed mid-beat of a D-cache write (`wdata` 0xDEADBEEF) → `m_wen`=0 and `d_busy`=1 immediately; next request re-arbitrates with D-cache priority.
- With `CACHE_ARB_STATS_EN` defined: 3 I-cache grants, 2 D-cache grants, 1 tie → `grant_cnt_i`=3, `grant_cnt_d`=2, `conflict_cnt`=1.
